// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types and helpers; PARITY state exists only with UART_RX_PARITY_EN
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver-to-consumer byte handshake and status; rx_parity_err present only with UART_RX_PARITY_EN
interface uart_rx_if;
  logic [uart_pkg::DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic rx_frame_err;
  logic rx_overrun;
  logic rx_busy;
`ifdef UART_RX_PARITY_EN
  logic rx_parity_err;
`endif
  modport master (
    input rx_ready,
    output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
`ifdef UART_RX_PARITY_EN
    , output rx_parity_err
`endif
  );
  modport slave (
    output rx_ready,
    input rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
`ifdef UART_RX_PARITY_EN
    , input rx_parity_err
`endif
  );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk) begin
    if (rst) {q, s1} <= {RST_VAL, RST_VAL};
    else {q, s1} <= {s1, d};
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with one-entry holding register; define UART_RX_PARITY_EN for 8E1 with parity check
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE = 115200
) (
  input logic CLK,
  input logic RESET,
  input logic RXD,
  uart_rx_if.master rx
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] shreg;
  logic rxs, prev, tick, half, done, ferr, par_ok;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(CLK), .rst(RESET), .d(RXD), .q(rxs));
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign rx.rx_busy = state != IDLE;
`ifdef UART_RX_PARITY_EN
  logic par, perr;
  assign par_ok = ~^{shreg, par};
`else
  assign par_ok = 1'b1;
`endif
  always_comb begin
    state_n = state;
    done = 1'b0;
    ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr = 1'b0;
`endif
    case (state)
      IDLE: state_n = prev & ~rxs ? START : IDLE;
      START: if (half) state_n = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA: if (tick && idx == IW'(DATA_BITS - 1)) state_n = PARITY;
      PARITY: if (tick) state_n = STOP;
`else
      DATA: if (tick && idx == IW'(DATA_BITS - 1)) state_n = STOP;
`endif
      STOP: if (tick) begin
        state_n = rxs ? IDLE : BREAK;
        ferr = ~rxs;
        done = rxs & par_ok;
`ifdef UART_RX_PARITY_EN
        perr = rxs & ~par_ok;
`endif
      end
      BREAK: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      prev <= 1'b1;
      rx.rx_data <= '0;
      rx.rx_valid <= 1'b0;
      rx.rx_frame_err <= 1'b0;
      rx.rx_overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state || tick ? '0 : cnt + 1'b1;
      prev <= rxs;
      idx <= state != DATA ? '0 : tick ? idx + 1'b1 : idx;
      if (state == DATA && tick) shreg <= {rxs, shreg[DATA_BITS-1:1]};
      rx.rx_frame_err <= ferr;
      rx.rx_overrun <= done & rx.rx_valid & ~rx.rx_ready;
      if (done && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data <= shreg;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_ready) rx.rx_valid <= 1'b0;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      par <= 1'b0;
      rx.rx_parity_err <= 1'b0;
    end else begin
      if (state == PARITY && tick) par <= rxs;
      rx.rx_parity_err <= perr;
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx: vector table, corner sequences, random frames against a frame-level model
module tb_uart_rx;
  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FB = 9;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FB = 8;
`endif
  localparam int LAT = 98 + (PAR_EN ? CPB : 0);
  typedef struct {
    logic [7:0] d;
    logic stop;
    logic exp_valid;
    logic [7:0] exp_data;
    int exp_ferr;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  uart_rx_if rx();
  uart_rx #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000)) dut (.CLK(clk), .RESET(rst), .RXD(rxd), .rx(rx));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int n_ferr = 0;
  int n_ovr = 0;
`ifdef UART_RX_PARITY_EN
  int n_perr = 0;
`endif
  logic [7:0] got[$];
  always @(negedge clk) begin
    if (rx.rx_frame_err) n_ferr++;
    if (rx.rx_overrun) n_ovr++;
    if (rx.rx_valid && rx.rx_ready) got.push_back(rx.rx_data);
`ifdef UART_RX_PARITY_EN
    if (rx.rx_parity_err) n_perr++;
`endif
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [8:0] fbits(input logic [7:0] d, input logic bad_par);
    return {(^d) ^ bad_par, d};
  endfunction
  task automatic send(input logic [8:0] bits, input logic stop);
    rxd = 1'b0;
    cyc(CPB);
    for (int i = 0; i < FB; i++) begin
      rxd = bits[i];
      cyc(CPB);
    end
    rxd = stop;
    cyc(CPB);
  endtask
  task automatic drain;
    rx.rx_ready = 1'b1;
    cyc(1);
    rx.rx_ready = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t vecs[6];
    int lat, base_f, base_o, ef, ep;
    logic [7:0] exp_q[$];
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};
    rx.rx_ready = 1'b0;
    cyc(3);
    chk("reset rx_data", rx.rx_data, 8'h00);
    chk("reset rx_valid", rx.rx_valid, 1'b0);
    chk("reset rx_frame_err", rx.rx_frame_err, 1'b0);
    chk("reset rx_overrun", rx.rx_overrun, 1'b0);
    chk("reset rx_busy", rx.rx_busy, 1'b0);
    rst = 1'b0;
    cyc(2);
    fork
      send(fbits(8'hA5, 1'b0), 1'b1);
      begin
        lat = 0;
        while (!rx.rx_valid && lat < 300) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    chk("single latency", lat, LAT);
    chk("single data", rx.rx_data, 8'hA5);
    chk("single valid held", rx.rx_valid, 1'b1);
    drain;
    chk("single drained", rx.rx_valid, 1'b0);
    base_f = n_ferr;
    rxd = 1'b0;
    cyc(3);
    rxd = 1'b1;
    chk("glitch busy", rx.rx_busy, 1'b1);
    cyc(20);
    chk("glitch idle", rx.rx_busy, 1'b0);
    chk("glitch valid", rx.rx_valid, 1'b0);
    chk("glitch ferr", n_ferr - base_f, 0);
    base_f = n_ferr;
    send(fbits(8'h3C, 1'b0), 1'b0);
    cyc(30);
    chk("frame err pulses", n_ferr - base_f, 1);
    chk("frame err valid", rx.rx_valid, 1'b0);
    chk("break busy", rx.rx_busy, 1'b1);
    rxd = 1'b1;
    cyc(5);
    chk("break exit", rx.rx_busy, 1'b0);
    send(fbits(8'h55, 1'b0), 1'b1);
    chk("after break data", rx.rx_data, 8'h55);
    chk("after break valid", rx.rx_valid, 1'b1);
    drain;
    foreach (vecs[i]) begin
      base_f = n_ferr;
      send(fbits(vecs[i].d, 1'b0), vecs[i].stop);
      rxd = 1'b1;
      cyc(5);
      chk($sformatf("vec%0d valid", i), rx.rx_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d data", i), rx.rx_data, vecs[i].exp_data);
      chk($sformatf("vec%0d ferr", i), n_ferr - base_f, vecs[i].exp_ferr);
      drain;
    end
    base_o = n_ovr;
    send(fbits(8'h11, 1'b0), 1'b1);
    send(fbits(8'h22, 1'b0), 1'b1);
    cyc(2);
    chk("overrun data kept", rx.rx_data, 8'h11);
    chk("overrun valid", rx.rx_valid, 1'b1);
    chk("overrun pulses", n_ovr - base_o, 1);
    drain;
    base_o = n_ovr;
    send(fbits(8'h11, 1'b0), 1'b1);
    got.delete();
    fork
      send(fbits(8'h22, 1'b0), 1'b1);
      begin
        cyc(LAT - 1);
        rx.rx_ready = 1'b1;
        cyc(1);
        rx.rx_ready = 1'b0;
      end
    join
    cyc(2);
    chk("drain-on-complete data", rx.rx_data, 8'h22);
    chk("drain-on-complete valid", rx.rx_valid, 1'b1);
    chk("drain-on-complete overrun", n_ovr - base_o, 0);
    chk("drain-on-complete accepts", got.size(), 1);
    chk("drain-on-complete first", got.size() > 0 ? got[0] : 8'hxx, 8'h11);
    fork
      send(fbits(8'hFF, 1'b0), 1'b1);
      begin
        cyc(55);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midreset valid", rx.rx_valid, 1'b0);
        chk("midreset data", rx.rx_data, 8'h00);
        chk("midreset busy", rx.rx_busy, 1'b0);
        chk("midreset ferr", rx.rx_frame_err, 1'b0);
      end
    join
    cyc(20);
    chk("midreset no byte", rx.rx_valid, 1'b0);
    send(fbits(8'h81, 1'b0), 1'b1);
    chk("post reset data", rx.rx_data, 8'h81);
    chk("post reset valid", rx.rx_valid, 1'b1);
    drain;
`ifdef UART_RX_PARITY_EN
    base_o = n_perr;
    send(fbits(8'h07, 1'b0), 1'b1);
    cyc(2);
    chk("parity good valid", rx.rx_valid, 1'b1);
    chk("parity good data", rx.rx_data, 8'h07);
    drain;
    send(fbits(8'h07, 1'b1), 1'b1);
    cyc(2);
    chk("parity bad pulse", n_perr - base_o, 1);
    chk("parity bad valid", rx.rx_valid, 1'b0);
    base_f = n_ferr;
    base_o = n_perr;
    send(fbits(8'h07, 1'b1), 1'b0);
    rxd = 1'b1;
    cyc(5);
    chk("parity vs frame ferr", n_ferr - base_f, 1);
    chk("parity vs frame perr", n_perr - base_o, 0);
`endif
    rx.rx_ready = 1'b1;
    got.delete();
    exp_q.delete();
    base_f = n_ferr;
    ef = 0;
    ep = 0;
`ifdef UART_RX_PARITY_EN
    base_o = n_perr;
`endif
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic stop, bad;
      d = 8'($urandom);
      stop = $urandom_range(0, 5) != 0;
      bad = PAR_EN && $urandom_range(0, 4) == 0;
      send(fbits(d, bad), stop);
      if (!stop) ef++;
      else if (bad) ep++;
      else exp_q.push_back(d);
      rxd = 1'b1;
      cyc(stop ? $urandom_range(0, 4) : $urandom_range(4, 8));
    end
    cyc(20);
    rx.rx_ready = 1'b0;
    chk("random byte count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("random byte %0d", i), got[i], exp_q[i]);
    chk("random frame errors", n_ferr - base_f, ef);
`ifdef UART_RX_PARITY_EN
    chk("random parity errors", n_perr - base_o, ep);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
